// File: rtl/cpu_types_pkg.sv
// Shared core types: data word, jump immediate width and the fetch FSM state encoding.
package cpu_types_pkg;

   localparam int unsigned ADDR_W = 26;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      REDIR_WAIT = 2'd1,
      HALTED     = 2'd2
   } fetch_state_t;

   // Instruction addresses are word aligned; drop the byte offset.
   function automatic word_t align_pc(input word_t addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Redirect target select: taken branch over jump, JR over J/JAL; result is word aligned.
module pc_target_mux
   import cpu_types_pkg::*;
(
   input  logic              br_taken,
   input  word_t             br_target,
   input  logic              j_reg,
   input  word_t             j_pc4,
   input  logic [ADDR_W-1:0] imm26,
   input  word_t             jr_target,
   output word_t             target
);

   always_comb begin
      target = '0;
      if (br_taken) begin
         target = align_pc(br_target);
      end else if (j_reg) begin
         target = align_pc(jr_target);
      end else begin
         target = {j_pc4[31:28], imm26, 2'b00};
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction fetch sequencer (RUN / REDIR_WAIT / HALTED).
// Optional FETCH_PERF_EN adds saturating fetch_cnt / stall_cnt counters.
module fetch_sequencer
   import cpu_types_pkg::*;
#(
   parameter word_t PC_RESET = 32'h0000_0000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ihit,
   input  logic              stall,
   input  logic              halt,
   input  logic              br_taken,
   input  word_t             br_target,
   input  logic              j_valid,
   input  logic              j_reg,
   input  word_t             j_pc4,
   input  logic [ADDR_W-1:0] imm26,
   input  word_t             jr_target,
`ifdef FETCH_PERF_EN
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt,
`endif
   output logic              iREN,
   output word_t             imemaddr,
   output word_t             pc4,
   output logic              fetch_valid,
   output logic              flush,
   output logic              halted
);

   fetch_state_t state;
   word_t        pc;
   word_t        saved_tgt;
   word_t        target;
   logic         redir;
   logic         active;

   pc_target_mux u_target_mux (
      .br_taken  (br_taken),
      .br_target (br_target),
      .j_reg     (j_reg),
      .j_pc4     (j_pc4),
      .imm26     (imm26),
      .jr_target (jr_target),
      .target    (target)
   );

   assign redir  = br_taken | j_valid;
   // Outputs stay quiet while reset is held and come alive as soon as it drops.
   assign active = ~RST;

   always_comb begin
      imemaddr    = pc;
      pc4         = pc + 32'd4;
      halted      = (state == HALTED);
      iREN        = active & (state != HALTED);
      flush       = active & redir & (state != HALTED);
      fetch_valid = active & (state == RUN) & ihit & ~stall & ~redir & ~halt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= RUN;
         pc        <= align_pc(PC_RESET);
         saved_tgt <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (halt) begin
                  state <= HALTED;
               end else if (redir) begin
                  if (ihit) begin
                     pc <= target;
                  end else begin
                     // Miss in flight for the current address: park the target.
                     saved_tgt <= target;
                     state     <= REDIR_WAIT;
                  end
               end else if (!stall && ihit) begin
                  pc <= pc + 32'd4;
               end
            end
            REDIR_WAIT: begin
               if (halt) begin
                  state <= HALTED;
               end else if (ihit) begin
                  pc    <= redir ? target : saved_tgt;
                  state <= RUN;
               end else if (redir) begin
                  saved_tgt <= target;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= HALTED;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else if (state != HALTED) begin
         if (fetch_valid && fetch_cnt != 32'hFFFF_FFFF) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (iREN && !fetch_valid && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
